// File: rtl/imm_decode_ctrl.sv
// Purpose: decode-stage controller; classifies RV32I opcodes and forms the immediate for execute.
// Latency: 2 cycles from acceptance to out_valid, 1 instruction/cycle sustained.
// Backpressure: valid/ready both sides; holds 2 entries when out_ready=0, in_ready follows out_ready combinationally.

package imm_decode_pkg;
    typedef enum logic [2:0] {
        RV32_TYPE_I = 3'd0,
        RV32_TYPE_S = 3'd1,
        RV32_TYPE_B = 3'd2,
        RV32_TYPE_U = 3'd3,
        RV32_TYPE_J = 3'd4
    } rv32_type_enum_t;

    typedef logic [31:0] riscv_instr_t;
    typedef logic [31:0] rv_imm_t;
endpackage

// Purpose: combinational immediate generator for one RV32I format.
// Latency: 0 cycles.
// Backpressure: none (pure function of its inputs).
module imm_gen
    import imm_decode_pkg::*;
(
    input  riscv_instr_t    instr,
    input  rv32_type_enum_t imm_type,
    output rv_imm_t         imm
);
    // B and J are delivered as half-offsets (bit 0 dropped); execute shifts them back.
    always_comb begin
        imm = '0;
        case (imm_type)
            RV32_TYPE_I: imm = {{20{instr[31]}}, instr[31:20]};
            RV32_TYPE_S: imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            RV32_TYPE_B: imm = {{20{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8]};
            RV32_TYPE_U: imm = {instr[31:12], 12'b0};
            RV32_TYPE_J: imm = {{12{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21]};
            default:     imm = '0;
        endcase
    end
endmodule

// Purpose: 2-stage decode pipeline (classify in S1, register immediate in S2) with flush and illegal counter.
// Latency: accepted at edge N, visible on out_* after edge N+1.
// Backpressure: each stage advances when downstream is empty or draining; in_ready low during flush.
module imm_decode_ctrl
    import imm_decode_pkg::*;
#(
    parameter int NUM_HARTS = 8,
    parameter int CNT_W     = 16,
    localparam int HW       = $clog2(NUM_HARTS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [HW-1:0]    in_hart_id,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic [HW-1:0]    out_hart_id,
    output logic [2:0]       out_imm_type,
    output logic [31:0]      out_imm,
    output logic             out_has_imm,
    output logic             out_illegal,
    output logic [CNT_W-1:0] illegal_cnt
);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    rv32_type_enum_t in_type;
    logic            in_has_imm;
    logic            in_illegal;

    logic            s1_valid;
    riscv_instr_t    s1_instr;
    logic [HW-1:0]   s1_hart_id;
    rv32_type_enum_t s1_type;
    logic            s1_has_imm;
    logic            s1_illegal;
    rv_imm_t         s1_imm;

    logic            s2_valid;
    riscv_instr_t    s2_instr;
    logic [HW-1:0]   s2_hart_id;
    rv32_type_enum_t s2_type;
    rv_imm_t         s2_imm;
    logic            s2_has_imm;
    logic            s2_illegal;

    logic            s1_adv;
    logic            s2_adv;
    logic            deliver;

    assign s2_adv   = !s2_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv && !flush;
    assign deliver  = s2_valid && out_ready;

    // Opcode classification of the incoming word; OP and unknown opcodes fall back to I with no immediate.
    always_comb begin
        in_type    = RV32_TYPE_I;
        in_has_imm = 1'b1;
        in_illegal = 1'b0;
        case (in_instr[6:0])
            7'b0110111, 7'b0010111: in_type = RV32_TYPE_U;
            7'b1101111:             in_type = RV32_TYPE_J;
            7'b1100011:             in_type = RV32_TYPE_B;
            7'b0100011:             in_type = RV32_TYPE_S;
            7'b1100111, 7'b0000011, 7'b0010011,
            7'b0001111, 7'b1110011: in_type = RV32_TYPE_I;
            7'b0110011:             in_has_imm = 1'b0;
            default: begin
                in_has_imm = 1'b0;
                in_illegal = 1'b1;
            end
        endcase
    end

    imm_gen u_imm_gen (
        .instr    (s1_instr),
        .imm_type (s1_type),
        .imm      (s1_imm)
    );

    // Stage valid bits; flush wins over any advance in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else if (flush) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (s2_adv) s2_valid <= s1_valid;
            if (s1_adv) s1_valid <= in_valid;
        end
    end

    // Stage payloads load only on a real transfer so stalled stages stay bit-stable.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_instr   <= '0;
            s1_hart_id <= '0;
            s1_type    <= RV32_TYPE_I;
            s1_has_imm <= 1'b0;
            s1_illegal <= 1'b0;
            s2_instr   <= '0;
            s2_hart_id <= '0;
            s2_type    <= RV32_TYPE_I;
            s2_imm     <= '0;
            s2_has_imm <= 1'b0;
            s2_illegal <= 1'b0;
        end else begin
            if (in_valid && in_ready) begin
                s1_instr   <= in_instr;
                s1_hart_id <= in_hart_id;
                s1_type    <= in_type;
                s1_has_imm <= in_has_imm;
                s1_illegal <= in_illegal;
            end
            if (s1_valid && s2_adv && !flush) begin
                s2_instr   <= s1_instr;
                s2_hart_id <= s1_hart_id;
                s2_type    <= s1_type;
                s2_imm     <= s1_has_imm ? s1_imm : '0;
                s2_has_imm <= s1_has_imm;
                s2_illegal <= s1_illegal;
            end
        end
    end

    // Saturating count of illegal opcodes handed to execute; a delivery in a flush cycle still counts.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            illegal_cnt <= '0;
        end else if (deliver && s2_illegal && (illegal_cnt != CNT_MAX)) begin
            illegal_cnt <= illegal_cnt + CNT_ONE;
        end
    end

    assign out_valid    = s2_valid;
    assign out_instr    = s2_instr;
    assign out_hart_id  = s2_hart_id;
    assign out_imm_type = s2_type;
    assign out_imm      = s2_imm;
    assign out_has_imm  = s2_has_imm;
    assign out_illegal  = s2_illegal;
endmodule

// File: doc/imm_decode_ctrl.md
# imm_decode_ctrl

Decode-stage controller for the pito pipeline. Accepts fetched instructions tagged with a hart id over a valid/ready handshake. Classifies each opcode into an immediate format and drives an internal `imm_gen` instance with that format. Delivers the decoded immediate and its metadata to execute through a 2-stage, full-throughput, back-pressurable pipeline with flush and an illegal-opcode counter.

## Interface

Parameters:
- `NUM_HARTS`, default 8: number of harts; hart id width `HW = $clog2(NUM_HARTS)`.
- `CNT_W`, default 16: width of the illegal-opcode counter.

Ports:
- `clk`  in  1: single clock.
- `rst_n`  in  1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `in_valid`  in  1: instruction present.
- `in_ready`  out  1: block accepts `in_*` this cycle.
- `in_instr`  in  32: RV32I instruction word (`riscv_instr_t`).
- `in_hart_id`  in  HW: issuing hart.
- `flush`  in  1: drop all in-flight entries.
- `out_valid`  out  1: decoded result present.
- `out_ready`  in  1: consumer takes result.
- `out_instr`  out  32: instruction word, passed through.
- `out_hart_id`  out  HW: hart id, passed through.
- `out_imm_type`  out  `rv32_type_enum_t`: selected immediate format.
- `out_imm`  out  32: decoded immediate (`rv_imm_t`).
- `out_has_imm`  out  1: instruction carries an immediate.
- `out_illegal`  out  1: opcode not recognised.
- `illegal_cnt`  out  CNT_W: saturating count of illegal opcodes delivered.

## Operation

Opcode classification is on `instr[6:0]` and happens in stage 1:
- 0110111 LUI and 0010111 AUIPC → U.
- 1101111 JAL → J.
- 1100011 BRANCH → B.
- 0100011 STORE → S.
- 1100111 JALR, 0000011 LOAD, 0010011 OP-IMM, 0001111 MISC-MEM, 1110011 SYSTEM → I.
- 0110011 OP → I format, `has_imm=0`, `out_imm` forced to 0.
- Any other opcode → I format, `illegal=1`, `has_imm=0`, `out_imm` forced to 0.

Immediate formation:
- Stage 2 registers the `imm_gen` output computed from the stage-1 instruction and type.
- B and J immediates are half-offsets: `offset[12:1]` / `offset[20:1]`, sign-extended, with bit 0 not appended. Execute shifts left by 1.
- U immediate is `instr[31:12] << 12`.

Pipeline:
- Two stages (S1, S2), each with its own valid bit.
- `s2_adv = !s2_valid || out_ready`.
- `s1_adv = !s1_valid || s2_adv`.
- `in_ready = s1_adv && !flush`.
- Transfer occurs when valid and ready are both high. Stage data loads only when its stage advances. A stalled stage holds all fields stable.

Flush:
- `flush=1` clears `s1_valid` and `s2_valid` on the next edge.
- `in_ready` is 0 during a flush cycle, so no instruction is accepted.
- Flush has priority over every transfer in the same cycle. An `out_valid && out_ready` in a flush cycle still counts as delivered to the consumer.

Illegal counter:
- Increments by 1 on every delivered output (`out_valid && out_ready`) with `out_illegal=1`.
- Saturates at `2^CNT_W-1`.
- Is not cleared by `flush`.

Reset (`rst_n=0` at an edge):
- All valids, all data registers and `illegal_cnt` go to 0.
- `out_imm_type` resets to `RV32_TYPE_I`.
- In-flight entries are discarded with no output.
- `in_ready` reads 1 from the first cycle after reset deasserts.

## Timing

- Latency: an instruction accepted at edge N presents `out_valid=1` in the cycle after edge N+1 (2 edges), given no stall.
- Throughput: 1 instruction/cycle while `out_ready=1`.
- Back-pressure: with `out_ready=0`, the pipeline absorbs exactly 2 instructions and then `in_ready` drops to 0. `in_ready` is combinational from `out_ready`, with no bubble on release.
- Outputs hold while `out_valid && !out_ready`.
- `illegal_cnt` updates on the edge that completes the transfer.
- Simultaneous `in_valid` and `out_ready` with both stages full: S2 drains, S1 moves to S2 and the new instruction enters S1 in the same edge.

## Test plan

- **Immediate decode sweep, one instruction per cycle with `out_ready=1`:**
  - `0xFFF00093` (addi -1) → I, `0xFFFFFFFF`.
  - `0x123452B7` (lui) → U, `0x12345000`.
  - `0x0020A423` (sw 8) → S, `0x00000008`.
  - `0xFE000EE3` (beq -4) → B, `0xFFFFFFFE`.
  - Each arrives 2 edges after acceptance, in order.
- **Non-immediate and illegal opcodes:**
  - `0x002081B3` (add) → `has_imm=0`, `imm=0`, `illegal=0`.
  - `0x0000007F` → `illegal=1`, `imm=0`, `illegal_cnt` goes 0→1.
- **Back-pressure:** hold `out_ready=0` and offer 4 instructions → exactly 2 accepted, `in_ready=0`, outputs stable. Release → remaining 2 accepted with no bubble, order and hart ids preserved.
- **Flush:** flush with both stages full and `in_valid=1` → next cycle `out_valid=0`, no accept during the flush cycle. Next instruction appears 2 edges after acceptance.
- **Counter saturation:** preload `illegal_cnt` via 65 535 illegal deliveries, then deliver 3 more → `illegal_cnt` stays `0xFFFF`.
- **Reset mid-stream:** assert `rst_n=0` for one edge with both stages valid → all outputs 0 and `out_imm_type=I`, nothing delivered, `in_ready=1` the following cycle.
